// File: rtl/multiword_add_sequencer_if.sv
// Request/result handshake bundle for multiword_add_sequencer.
// master drives operands and out_ready; slave is the sequencer itself.
interface multiword_add_sequencer_if #(
    parameter int WORDS = 4
);
    localparam int N = 16 * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         overflow;
    logic         busy;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, overflow, busy
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, overflow, busy
    );
endinterface

// File: rtl/multiword_add_sequencer.sv
// Serial multiword adder/subtractor: one 16-bit carry-chained slice per clock,
// LSB first, with a valid/ready request and result handshake.
module multiword_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic clk,
    input  logic rst,
    multiword_add_sequencer_if.slave bus
);
    localparam int N  = 16 * WORDS;
    localparam int IW = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_reg;
    logic [IW-1:0] idx_reg;
    logic          carry_reg;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  b_reg;
    logic [N-1:0]  sum_reg;
    logic          cout_reg;
    logic          overflow_reg;
    logic          in_ready_reg;
    logic          out_valid_reg;
    logic          busy_reg;

    logic [15:0] a_slice [WORDS];
    logic [15:0] b_slice [WORDS];
    logic [15:0] cur_a;
    logic [15:0] cur_b;
    logic [16:0] slice_sum;
    logic        msb_carry_in;

    for (genvar gi = 0; gi < WORDS; gi++) begin : g_slice
        assign a_slice[gi] = a_reg[16*gi +: 16];
        assign b_slice[gi] = b_reg[16*gi +: 16];
    end

    // Carry into bit 15 of the current slice is recovered from the sum bit;
    // it only matters on the top slice, where it feeds the overflow flag.
    always_comb begin
        cur_a        = a_slice[idx_reg];
        cur_b        = b_slice[idx_reg];
        slice_sum    = {1'b0, cur_a} + {1'b0, cur_b} + {16'd0, carry_reg};
        msb_carry_in = cur_a[15] ^ cur_b[15] ^ slice_sum[15];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            carry_reg     <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid && in_ready_reg) begin
                        // Subtraction is a + ~b + 1, so invert b once here.
                        a_reg        <= bus.a;
                        b_reg        <= bus.sub ? ~bus.b : bus.b;
                        carry_reg    <= bus.sub | bus.cin;
                        idx_reg      <= '0;
                        state_reg    <= RUN;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end
                RUN: begin
                    for (int w = 0; w < WORDS; w++) begin
                        if (idx_reg == IW'(w)) begin
                            sum_reg[16*w +: 16] <= slice_sum[15:0];
                        end
                    end
                    carry_reg <= slice_sum[16];
                    if (idx_reg == IW'(WORDS - 1)) begin
                        idx_reg       <= '0;
                        cout_reg      <= slice_sum[16];
                        overflow_reg  <= msb_carry_in ^ slice_sum[16];
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        idx_reg <= idx_reg + IW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    in_ready_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.sum       = sum_reg;
    assign bus.cout      = cout_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench for multiword_add_sequencer: vector table, backpressure,
// mid-operation reset and back-to-back random traffic against a reference model.
module tb_multiword_add_sequencer;
    localparam int WORDS = 4;
    localparam int N     = 16 * WORDS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multiword_add_sequencer_if #(.WORDS(WORDS)) bus ();
    multiword_add_sequencer #(.WORDS(WORDS)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic         sub;
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[9];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    function automatic exp_t ref_calc(input logic [N-1:0] a, input logic [N-1:0] b,
                                      input logic cin, input logic sub);
        exp_t         e;
        logic [N-1:0] bb;
        logic [N:0]   full;
        bb     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, (sub ? 1'b1 : cin)};
        e.sum  = full[N-1:0];
        e.cout = full[N];
        e.ovf  = (a[N-1] == bb[N-1]) && (full[N-1] != a[N-1]);
        return e;
    endfunction

    // Present one request and return #1 after its acceptance edge; the
    // operand lines are then scrambled to show they are no longer sampled.
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic cin, input logic sub, input exp_t e);
        int t = 0;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!bus.in_ready) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%b, expected 1", bus.in_ready);
        end
        @(posedge clk);
        sbq.push_back(e);
        #1;
        bus.in_valid = 1'b0;
        bus.a   = {$urandom, $urandom};
        bus.b   = {$urandom, $urandom};
        bus.cin = 1'($urandom);
        bus.sub = 1'($urandom);
    endtask

    // Called #1 after acceptance with out_ready=1: checks latency, result and release.
    task automatic collect(input string nm);
        int   lat = 0;
        exp_t e;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({nm, "_latency"}, N'(lat), N'(WORDS));
        if (!bus.out_valid) return;
        if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s_scoreboard: got result, expected empty queue", nm);
            return;
        end
        e = sbq.pop_front();
        check({nm, "_sum"}, bus.sum, e.sum);
        check({nm, "_cout"}, N'(bus.cout), N'(e.cout));
        check({nm, "_ovf"}, N'(bus.overflow), N'(e.ovf));
        $display("txn %s: sum=%h cout=%b ovf=%b (exp %h %b %b) latency=%0d",
                 nm, bus.sum, bus.cout, bus.overflow, e.sum, e.cout, e.ovf, lat);
        @(posedge clk);
        #1;
        check({nm, "_release_valid"}, N'(bus.out_valid), N'(0));
        check({nm, "_release_ready"}, N'(bus.in_ready), N'(1));
    endtask

    initial begin
        exp_t e;
        vecs[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
        vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[3] = '{64'h5, 64'h7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[4] = '{64'h7, 64'h5, 1'b0, 1'b1, 64'h2, 1'b1, 1'b0};
        vecs[5] = '{64'h1234, 64'h0, 1'b1, 1'b0, 64'h1235, 1'b0, 1'b0};
        vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0};
        vecs[7] = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vecs[8] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", N'(bus.in_ready), N'(1));
        check("reset_out_valid", N'(bus.out_valid), N'(0));
        check("reset_busy", N'(bus.busy), N'(0));
        check("reset_sum", bus.sum, '0);
        check("reset_cout_ovf", N'({bus.cout, bus.overflow}), N'(0));
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            e = '{vecs[i].sum, vecs[i].cout, vecs[i].ovf};
            send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, e);
            check($sformatf("vec%0d_busy", i), N'(bus.busy), N'(1));
            collect($sformatf("vec%0d", i));
        end

        // Results persist in IDLE until the next run.
        repeat (3) @(posedge clk);
        #1;
        check("idle_hold_sum", bus.sum, vecs[8].sum);

        // Backpressure: result held for 10 cycles with out_ready low.
        bus.out_ready = 1'b0;
        e = ref_calc(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b1, 1'b0);
        send(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b1, 1'b0, e);
        begin
            int   t = 0;
            exp_t h;
            int   bad = 0;
            while (!bus.out_valid && t < 20) begin
                @(posedge clk);
                #1;
                t++;
            end
            check("bp_latency", N'(t), N'(WORDS));
            h = sbq.pop_front();
            for (int k = 0; k < 10; k++) begin
                @(posedge clk);
                #1;
                if (!bus.out_valid || bus.in_ready || bus.sum !== h.sum ||
                    bus.cout !== h.cout || bus.overflow !== h.ovf) bad++;
            end
            check("bp_hold_cycles_bad", N'(bad), N'(0));
            check("bp_sum", bus.sum, h.sum);
            $display("txn backpressure: sum=%h cout=%b held 10 cycles", bus.sum, bus.cout);
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            check("bp_release_valid", N'(bus.out_valid), N'(0));
            check("bp_release_ready", N'(bus.in_ready), N'(1));
        end

        // Mid-operation reset at idx=2, then a clean request.
        e = ref_calc(64'hAAAA_BBBB_CCCC_DDDD, 64'h1, 1'b0, 1'b0);
        send(64'hAAAA_BBBB_CCCC_DDDD, 64'h1, 1'b0, 1'b0, e);
        void'(sbq.pop_back());
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mrst_busy", N'(bus.busy), N'(0));
        check("mrst_sum", bus.sum, '0);
        check("mrst_in_ready", N'(bus.in_ready), N'(1));
        begin
            int seen = 0;
            for (int k = 0; k < 8; k++) begin
                if (bus.out_valid) seen++;
                @(posedge clk);
                #1;
            end
            check("mrst_no_out_valid", N'(seen), N'(0));
        end
        $display("txn mid_reset: aborted request, sum=%h busy=%b", bus.sum, bus.busy);
        e = ref_calc(64'hFFFF_0000_FFFF_0000, 64'h0001_FFFF_0001_0000, 1'b0, 1'b1);
        send(64'hFFFF_0000_FFFF_0000, 64'h0001_FFFF_0001_0000, 1'b0, 1'b1, e);
        collect("after_reset");

        // Back-to-back: in_valid held, out_ready held, 8 random requests.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    int           t = 0;
                    logic [N-1:0] ra;
                    logic [N-1:0] rb;
                    logic         rc;
                    logic         rs;
                    while (!bus.in_ready && t < 50) begin
                        @(negedge clk);
                        t++;
                    end
                    if (!bus.in_ready) begin
                        checks++; errors++;
                        $display("FAIL b2b_accept_timeout: in_ready=0, expected 1");
                        break;
                    end
                    ra = {$urandom, $urandom};
                    rb = {$urandom, $urandom};
                    rc = 1'($urandom);
                    rs = 1'($urandom);
                    bus.a = ra; bus.b = rb; bus.cin = rc; bus.sub = rs;
                    bus.in_valid = 1'b1;
                    sbq.push_back(ref_calc(ra, rb, rc, rs));
                    @(posedge clk);
                    @(negedge clk);
                end
                bus.in_valid = 1'b0;
            end
            begin
                int   got = 0;
                int   guard = 0;
                int   last = 0;
                exp_t r;
                while (got < 8 && guard < 300) begin
                    @(negedge clk);
                    guard++;
                    if (bus.out_valid) begin
                        if (sbq.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL b2b_scoreboard: got result, expected empty queue");
                        end else begin
                            r = sbq.pop_front();
                            check($sformatf("b2b%0d_sum", got), bus.sum, r.sum);
                            check($sformatf("b2b%0d_flags", got),
                                  N'({bus.cout, bus.overflow}), N'({r.cout, r.ovf}));
                            $display("txn b2b%0d: sum=%h cout=%b ovf=%b at cycle %0d",
                                     got, bus.sum, bus.cout, bus.overflow, cyc);
                        end
                        if (got > 0) check($sformatf("b2b%0d_interval", got), N'(cyc - last), N'(WORDS + 2));
                        last = cyc;
                        got++;
                        @(negedge clk);
                    end
                end
                check("b2b_result_count", N'(got), N'(8));
            end
        join

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
